pipo_load_arbiter: RTL

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

---
 rtl/pipo_load_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipo_load_arbiter.sv
// Two-requester round-robin arbiter that loads a shared PIPO register.
// Each transfer goes through IDLE -> LOAD -> FULL, and the consumer releases FULL with rd_ack.
module pipo_load_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             rd_ack,
    output logic             load,
    output logic [WIDTH-1:0] pdata,
    output logic             gnt0,
    output logic             gnt1,
    output logic             owner,
    output logic             q_valid,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             load_q, load_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             owner_q, owner_d;
    logic             q_valid_q, q_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             winner;

    // On a contested request, the requester that did not win last time takes the grant.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~owner_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_d    = 1'b0;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        owner_d   = owner_q;
        pdata_d   = pdata_q;
        q_valid_d = q_valid_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    owner_d = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    pdata_d = winner ? data1 : data0;
                end
            end
            LOAD: begin
                state_d   = FULL;
                q_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            FULL: begin
                if (rd_ack) begin
                    state_d   = IDLE;
                    q_valid_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                q_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // owner resets to 1 so that requester 0 wins the first contested arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            owner_q   <= 1'b1;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            pdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            owner_q   <= owner_d;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            pdata_q   <= pdata_d;
        end
    end

    assign load    = load_q;
    assign pdata   = pdata_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign owner   = owner_q;
    assign q_valid = q_valid_q;
    assign busy    = busy_q;

endmodule
